// File: rtl/jt12_seq_pkg.sv
// Shared types and constants for the jt12 write sequencer.
//   seq_state_e : bus-replay FSM states
//   wr_entry_t  : one queued register write {part, reg_addr, data} (17 bits)
//   ADDR_PHASE / DATA_PHASE : value of jt12 addr[0] for each bus cycle
//   CNT_W       : width of the shared tick counter
package jt12_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StASetup,
    StAStrobe,
    StAHold,
    StDSetup,
    StDStrobe,
    StWait
  } seq_state_e;

  typedef struct packed {
    logic       part;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } wr_entry_t;

  localparam logic ADDR_PHASE = 1'b0;
  localparam logic DATA_PHASE = 1'b1;

  localparam int unsigned CNT_W = 16;

  // jt12 addr bus encoding: {part, is_data}
  function automatic logic [1:0] bus_addr(input logic part, input logic phase);
    return {part, phase};
  endfunction

endpackage

// File: rtl/jt12_wr_fifo.sv
// Write queue for the jt12 sequencer: synchronous FIFO, first-word-fall-through read.
// Ports:
//   clk_100mhz, reset   : system clock, asynchronous active-high reset (flushes the queue)
//   wr_en_i, wr_data_i  : push request and entry (ignored when full)
//   rd_en_i, rd_data_o  : pop request (ignored when empty); rd_data_o shows the head entry
//   full_o, empty_o     : occupancy flags
//   level_o             : number of entries held
module jt12_wr_fifo
  import jt12_seq_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                   clk_100mhz,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  wr_entry_t              wr_data_i,
  input  logic                   rd_en_i,
  output wr_entry_t              rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned LevelW = PtrW + 1;

  wr_entry_t           mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0]   level_q;
  logic                push, pop;

  assign full_o  = (level_q == LevelW'(Depth));
  assign empty_o = (level_q == '0);
  assign push    = wr_en_i & ~full_o;
  assign pop     = rd_en_i & ~empty_o;

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk_100mhz) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LevelW'(1);
        2'b01:   level_q <= level_q - LevelW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/jt12_write_sequencer.sv
// Queues YM2612 register writes from the 100 MHz domain and replays each one onto the jt12
// CPU bus as an address write followed by a data write, timed to 4 MHz rising edges
// (clk_4mhz is sampled as data), then waits out the chip's write-busy period.
// Build option: JT12_BUSY_POLL_EN -- when defined, the wait polls jt_dout7 (synchronized)
// with a BUSY_TIMEOUT tick limit; otherwise it waits a fixed WAIT_TICKS ticks.
// Ports:
//   clk_100mhz, reset          : system clock, asynchronous active-high reset
//   clk_4mhz                   : divider output, edge-detected into a one-cycle tick
//   wr_valid/wr_ready          : host push handshake (wr_ready = queue not full)
//   wr_part, wr_reg, wr_data   : write to queue
//   jt_cs_n, jt_wr_n           : jt12 chip select / write strobe, active-low
//   jt_addr, jt_din            : jt12 address {part, is_data} and data bus
//   jt_dout7                   : jt12 busy flag (used only with busy polling)
//   seq_busy                   : FSM active or queue non-empty
//   fifo_level                 : queued entries
//   timeout_err                : sticky busy-timeout flag (0 without busy polling)
module jt12_write_sequencer
  import jt12_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned STROBE_TICKS = 2,
  parameter int unsigned WAIT_TICKS   = 32,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic                        clk_100mhz,
  input  logic                        reset,
  input  logic                        clk_4mhz,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic                        wr_part,
  input  logic [7:0]                  wr_reg,
  input  logic [7:0]                  wr_data,
  output logic                        jt_cs_n,
  output logic                        jt_wr_n,
  output logic [1:0]                  jt_addr,
  output logic [7:0]                  jt_din,
  input  logic                        jt_dout7,
  output logic                        seq_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        timeout_err
);

  localparam logic [CNT_W-1:0] StrobeLd = CNT_W'(STROBE_TICKS);

  // 4 MHz rising-edge detect
  logic clk4_q, tick;
  assign tick = clk_4mhz & ~clk4_q;

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) clk4_q <= 1'b0;
    else       clk4_q <= clk_4mhz;
  end

  // Write queue
  wr_entry_t push_entry, head;
  logic      fifo_full, fifo_empty, pop;

  assign push_entry = '{part: wr_part, reg_addr: wr_reg, data: wr_data};
  assign wr_ready   = ~fifo_full;

  jt12_wr_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .wr_en_i    (wr_valid),
    .wr_data_i  (push_entry),
    .rd_en_i    (pop),
    .rd_data_o  (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

`ifdef JT12_BUSY_POLL_EN
  localparam logic [CNT_W-1:0] TimeoutLd = CNT_W'(BUSY_TIMEOUT);

  logic [1:0]       busy_sync_q;
  logic             busy_s, err_q, err_d;
  logic [CNT_W-1:0] unused_wait_ticks;

  assign unused_wait_ticks = CNT_W'(WAIT_TICKS);
  assign busy_s            = busy_sync_q[1];
  assign timeout_err       = err_q;

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      busy_sync_q <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      busy_sync_q <= {busy_sync_q[0], jt_dout7};
      err_q       <= err_d;
    end
  end
`else
  localparam logic [CNT_W-1:0] WaitLd = CNT_W'(WAIT_TICKS);

  logic             unused_dout7;
  logic [CNT_W-1:0] unused_busy_timeout;

  assign unused_dout7        = jt_dout7;
  assign unused_busy_timeout = CNT_W'(BUSY_TIMEOUT);
  assign timeout_err         = 1'b0;
`endif

  // Bus-replay FSM
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wr_entry_t        ent_q, ent_d;
  logic             cs_n_q, cs_n_d, wr_n_q, wr_n_d;
  logic [1:0]       addr_q, addr_d;
  logic [7:0]       din_q, din_d;

  assign jt_cs_n  = cs_n_q;
  assign jt_wr_n  = wr_n_q;
  assign jt_addr  = addr_q;
  assign jt_din   = din_q;
  assign seq_busy = (state_q != StIdle) | ~fifo_empty;

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ent_q   <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      addr_q  <= 2'b00;
      din_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ent_q   <= ent_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ent_d   = ent_q;
    cs_n_d  = cs_n_q;
    wr_n_d  = wr_n_q;
    addr_d  = addr_q;
    din_d   = din_q;
    pop     = 1'b0;
`ifdef JT12_BUSY_POLL_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          ent_d   = head;
          addr_d  = bus_addr(head.part, ADDR_PHASE);
          din_d   = head.reg_addr;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = StASetup;
        end
      end
      // The first tick only closes the partial period in which the bus was set up; the strobe
      // starts on the second, so address/data always lead wr_n by a full 4 MHz period.
      StASetup, StDSetup: begin
        if (tick) begin
          if (cnt_q != '0) begin
            wr_n_d  = 1'b0;
            cnt_d   = StrobeLd;
            state_d = (state_q == StASetup) ? StAStrobe : StDStrobe;
          end else begin
            cnt_d = CNT_W'(1);
          end
        end
      end
      StAStrobe, StDStrobe: begin
        if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            wr_n_d = 1'b1;
            if (state_q == StAStrobe) begin
              state_d = StAHold;
            end else begin
`ifdef JT12_BUSY_POLL_EN
              cnt_d = '0;
`else
              cnt_d = WaitLd;
`endif
              state_d = StWait;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      // Bus switches to the data phase one cycle after wr_n has risen.
      StAHold: begin
        addr_d  = bus_addr(ent_q.part, DATA_PHASE);
        din_d   = ent_q.data;
        cnt_d   = '0;
        state_d = StDSetup;
      end
      StWait: begin
`ifdef JT12_BUSY_POLL_EN
        // cnt_q counts ticks spent here; busy is only trusted after two of them.
        if (cnt_q >= CNT_W'(2) && !busy_s) begin
          cs_n_d  = 1'b1;
          state_d = StIdle;
        end else if (tick) begin
          if (cnt_q + CNT_W'(1) >= TimeoutLd) begin
            cs_n_d  = 1'b1;
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`else
        if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            cs_n_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_jt12_write_sequencer.sv
module tb_jt12_write_sequencer;

`ifdef JT12_BUSY_POLL_EN
  localparam int ExpWait = 2;
`else
  localparam int ExpWait = 32;
`endif

  logic       clk_100mhz = 1'b0;
  logic       reset      = 1'b1;
  logic       clk_4mhz   = 1'b0;
  logic       wr_valid   = 1'b0;
  logic       wr_part    = 1'b0;
  logic [7:0] wr_reg     = 8'h00;
  logic [7:0] wr_data    = 8'h00;
  logic       jt_dout7   = 1'b0;
  logic       wr_ready, jt_cs_n, jt_wr_n, seq_busy, timeout_err;
  logic [1:0] jt_addr;
  logic [7:0] jt_din;
  logic [3:0] fifo_level;

  int checks = 0;
  int errors = 0;

  jt12_write_sequencer dut (
    .clk_100mhz  (clk_100mhz),
    .reset       (reset),
    .clk_4mhz    (clk_4mhz),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_part     (wr_part),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .jt_cs_n     (jt_cs_n),
    .jt_wr_n     (jt_wr_n),
    .jt_addr     (jt_addr),
    .jt_din      (jt_din),
    .jt_dout7    (jt_dout7),
    .seq_busy    (seq_busy),
    .fifo_level  (fifo_level),
    .timeout_err (timeout_err)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // 250 ns period, edges on 10 ns boundaries (between 100 MHz rising edges)
  initial begin
    forever begin
      #130 clk_4mhz = 1'b1;
      #120 clk_4mhz = 1'b0;
    end
  end

  // Bus monitor: records each wr_n strobe and the tick count of each wait period.
  typedef struct {
    logic [1:0] addr;
    logic [7:0] din;
    int         setup;
    int         low;
  } strobe_t;

  strobe_t    sq[$];
  logic [1:0] prev_addr = 2'b00;
  logic [7:0] prev_din  = 8'h00;
  logic       prev_wr_n = 1'b1;
  logic       prev_cs_n = 1'b1;
  logic       prev_clk4 = 1'b0;
  int stable = 0, low_cnt = 0, setup_at_fall = 0, tick_cnt = 0;
  int bus_viol = 0, cs_falls = 0, wait_ticks_last = -1;

  always @(posedge clk_100mhz) begin
    #1;
    if (reset) begin
      stable  = 0;
      low_cnt = 0;
    end else begin
      if (jt_addr !== prev_addr || jt_din !== prev_din) begin
        stable = 0;
        if (!jt_wr_n || !prev_wr_n) bus_viol++;
      end else begin
        stable++;
      end
      if (clk_4mhz && !prev_clk4) tick_cnt++;
      if (prev_wr_n && !jt_wr_n) begin
        setup_at_fall = stable;
        low_cnt       = 1;
        if (jt_cs_n) bus_viol++;
      end else if (!jt_wr_n) begin
        low_cnt++;
      end else if (!prev_wr_n) begin
        sq.push_back('{addr: jt_addr, din: jt_din, setup: setup_at_fall, low: low_cnt});
        tick_cnt = 0;
      end
      if (prev_cs_n && !jt_cs_n) cs_falls++;
      if (!prev_cs_n && jt_cs_n) wait_ticks_last = tick_cnt;
    end
    prev_addr = jt_addr;
    prev_din  = jt_din;
    prev_wr_n = jt_wr_n;
    prev_cs_n = jt_cs_n;
    prev_clk4 = clk_4mhz;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Main-process sample point sits after the monitor's, so monitor data is current.
  task automatic step();
    @(posedge clk_100mhz);
    #2;
  endtask

  task automatic push(input logic p, input logic [7:0] r, input logic [7:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_part  = p;
    wr_reg   = r;
    wr_data  = d;
    while (!wr_ready && n < 5000) begin
      step();
      n++;
    end
    check("push_ready_within_budget", wr_ready, 1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (seq_busy && n < limit) begin
      step();
      n++;
    end
    check("idle_within_budget", seq_busy, 0);
  endtask

  typedef struct {
    logic       part;
    logic [7:0] rg;
    logic [7:0] dat;
    logic [1:0] ea;  // jt_addr during the address strobe
    logic [1:0] ed;  // jt_addr during the data strobe
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    vecs[0] = '{part: 1'b0, rg: 8'h28, dat: 8'hF0, ea: 2'd0, ed: 2'd1};
    vecs[1] = '{part: 1'b1, rg: 8'hA4, dat: 8'h22, ea: 2'd2, ed: 2'd3};
    vecs[2] = '{part: 1'b0, rg: 8'hB4, dat: 8'hC0, ea: 2'd0, ed: 2'd1};
    vecs[3] = '{part: 1'b1, rg: 8'h30, dat: 8'h7F, ea: 2'd2, ed: 2'd3};

    // Reset state
    repeat (3) step();
    check("rst_cs_n", jt_cs_n, 1);
    check("rst_wr_n", jt_wr_n, 1);
    check("rst_addr", jt_addr, 0);
    check("rst_din", jt_din, 0);
    check("rst_level", fifo_level, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_seq_busy", seq_busy, 0);
    check("rst_wr_ready", wr_ready, 1);
    reset = 1'b0;
    repeat (2) step();

    // Single writes from the table
    foreach (vecs[i]) begin
      sq.delete();
      push(vecs[i].part, vecs[i].rg, vecs[i].dat);
      wait_idle(3000);
      check($sformatf("v%0d_strobes", i), sq.size(), 2);
      if (sq.size() == 2) begin
        check($sformatf("v%0d_a_addr", i), sq[0].addr, vecs[i].ea);
        check($sformatf("v%0d_a_din", i), sq[0].din, vecs[i].rg);
        check($sformatf("v%0d_a_low", i), sq[0].low, 50);
        check($sformatf("v%0d_a_setup_ge25", i), sq[0].setup >= 25, 1);
        check($sformatf("v%0d_d_addr", i), sq[1].addr, vecs[i].ed);
        check($sformatf("v%0d_d_din", i), sq[1].din, vecs[i].dat);
        check($sformatf("v%0d_d_low", i), sq[1].low, 50);
        check($sformatf("v%0d_d_setup_ge25", i), sq[1].setup >= 25, 1);
      end
      check($sformatf("v%0d_wait_ticks", i), wait_ticks_last, ExpWait);
      check($sformatf("v%0d_cs_n_after", i), jt_cs_n, 1);
      check($sformatf("v%0d_level", i), fifo_level, 0);
    end

    // Back-to-back pushes: 9 accepted, then a 10th held while full
    sq.delete();
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_part  = i[0];
      wr_reg   = 8'h40 + 8'(i);
      wr_data  = 8'h90 + 8'(i);
      check($sformatf("b2b_ready_%0d", i), wr_ready, 1);
      step();
    end
    wr_part = 1'b1;
    wr_reg  = 8'h49;
    wr_data = 8'h99;
    check("b2b_level_full", fifo_level, 8);
    check("b2b_ready_low", wr_ready, 0);
    step();
    check("b2b_still_full", fifo_level, 8);
    push(1'b1, 8'h49, 8'h99);
    wait_idle(15000);
    check("b2b_strobes", sq.size(), 20);
    if (sq.size() == 20) begin
      for (int i = 0; i < 10; i++) begin
        check($sformatf("b2b_%0d_a_addr", i), sq[2*i].addr, {i[0], 1'b0});
        check($sformatf("b2b_%0d_a_din", i), sq[2*i].din, 8'h40 + i);
        check($sformatf("b2b_%0d_d_addr", i), sq[2*i+1].addr, {i[0], 1'b1});
        check($sformatf("b2b_%0d_d_din", i), sq[2*i+1].din, 8'h90 + i);
      end
    end
    check("b2b_level_end", fifo_level, 0);
    check("b2b_seq_busy_end", seq_busy, 0);

    // Reset mid address strobe with three entries queued
    for (int i = 0; i < 4; i++) push(1'b0, 8'h60 + 8'(i), 8'h10 + 8'(i));
    check("mid_level_before", fifo_level, 3);
    n = 0;
    while (jt_wr_n && n < 200) begin
      step();
      n++;
    end
    check("mid_strobe_started", jt_wr_n, 0);
    repeat (10) step();
    #1 reset = 1'b1;
    #1;
    check("mid_rst_wr_n", jt_wr_n, 1);
    check("mid_rst_cs_n", jt_cs_n, 1);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_addr", jt_addr, 0);
    check("mid_rst_din", jt_din, 0);
    check("mid_rst_seq_busy", seq_busy, 0);
    step();
    reset = 1'b0;
    sq.delete();
    n = cs_falls;
    repeat (1500) step();
    check("post_rst_no_strobe", sq.size(), 0);
    check("post_rst_no_cs", cs_falls - n, 0);
    check("post_rst_cs_n", jt_cs_n, 1);
    push(1'b1, 8'hA0, 8'h3C);
    wait_idle(3000);
    check("post_rst_new_strobes", sq.size(), 2);
    if (sq.size() == 2) check("post_rst_new_din", sq[1].din, 8'h3C);

`ifdef JT12_BUSY_POLL_EN
    // Busy held for 10 ticks after the data strobe
    begin
      int  tk;
      logic pk;
      sq.delete();
      push(1'b0, 8'h2B, 8'h80);
      n = 0;
      while (!(sq.size() == 1 && !jt_wr_n) && n < 3000) begin
        step();
        n++;
      end
      jt_dout7 = 1'b1;
      n = 0;
      while (sq.size() < 2 && n < 3000) begin
        step();
        n++;
      end
      check("poll_data_strobe_done", sq.size(), 2);
      tk = 0;
      n  = 0;
      pk = clk_4mhz;
      while (tk < 10 && n < 1000) begin
        step();
        n++;
        if (clk_4mhz && !pk) tk++;
        pk = clk_4mhz;
      end
      check("poll_cs_n_low_while_busy", jt_cs_n, 0);
      jt_dout7 = 1'b0;
      n = 0;
      while (!jt_cs_n && n < 20) begin
        step();
        n++;
      end
      check("poll_release_latency", n, 3);
      check("poll_no_timeout", timeout_err, 0);
      wait_idle(100);
    end

    // Busy stuck high: timeout after 255 ticks, sticky until reset
    jt_dout7 = 1'b1;
    push(1'b1, 8'h22, 8'h08);
    wait_idle(12000);
    check("stuck_wait_ticks", wait_ticks_last, 255);
    check("stuck_timeout_err", timeout_err, 1);
    jt_dout7 = 1'b0;
    repeat (50) step();
    check("stuck_timeout_sticky", timeout_err, 1);
    #1 reset = 1'b1;
    #1;
    check("stuck_timeout_cleared", timeout_err, 0);
    step();
    reset = 1'b0;
    step();
`endif

    check("bus_rule_violations", bus_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
